oam_line_scanner: RTL
=====================

OAM_LINE_SCANNER -- requirements
Module: oam_line_scanner

Interface
REQ-001 Parameter NUM_SPRITES, default 40: number of OAM entries scanned per line.
REQ-002 Parameter BUFFER_MAX, default 10: sprite buffer depth.
REQ-003 Parameter OAM_BASE, default 16'hFE00: OAM base address.
REQ-004 Derived IDX_W = $clog2(NUM_SPRITES), CNT_W = $clog2(BUFFER_MAX+1), ENTRY_W = IDX_W+12.
REQ-005 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 start_in  input  1  one-cycle pulse that begins a scan of the current line.
REQ-008 ly_in  input  8  scanline number, sampled on start_in.
REQ-009 tall_mode_in  input  1  sprite height 16 when 1, 8 when 0; sampled on start_in.
REQ-010 req_out  output  1  memory read request, held until rvalid_in.
REQ-011 addr_out  output  16  OAM byte address for the current request.
REQ-012 rdata_in  input  8  read data.
REQ-013 rvalid_in  input  1  rdata_in valid; completes the outstanding request.
REQ-014 rd_idx_in  input  CNT_W  buffer read index.
REQ-015 rd_entry_out  output  ENTRY_W  {sprite index, X byte, row[3:0]} at rd_idx_in, combinational.
REQ-016 count_out  output  CNT_W  number of valid buffer entries.
REQ-017 busy_out  output  1  scan in progress.
REQ-018 done_out  output  1  one-cycle pulse when the scan completes.

Function
REQ-019 States: IDLE, REQ_Y, REQ_X, DONE; start_in in any state -> REQ_Y with sprite index 0, count_out cleared, ly/tall latched.
REQ-020 REQ_Y: req_out=1, addr_out=OAM_BASE+4*idx; on rvalid_in, latch Y -> REQ_X.
REQ-021 REQ_X: req_out=1, addr_out=OAM_BASE+4*idx+1; on rvalid_in, evaluate the hit, then advance idx -> REQ_Y, or -> DONE after idx NUM_SPRITES-1.
REQ-022 Hit when Y <= ly+16 < Y+H (H=8 or 16) in 9-bit unsigned arithmetic; X value does not affect hit.
REQ-023 On a hit with count_out < BUFFER_MAX, store entry {idx, X, (ly+16-Y)[3:0]} at position count_out and increment count_out in the same cycle.
REQ-024 On a hit with count_out == BUFFER_MAX, discard the sprite; count_out saturates.
REQ-025 DONE lasts one cycle with done_out=1, then -> IDLE; buffer contents and count_out hold until the next start_in or reset.
REQ-026 busy_out=1 in REQ_Y and REQ_X; req_out=0 in IDLE and DONE.
REQ-027 rvalid_in while req_out=0 is ignored; at most one request outstanding.
REQ-028 Entries are stored in ascending OAM index order; rd_idx_in >= count_out returns 0.
REQ-029 start_in coincident with rvalid_in: start_in wins and the data is discarded.

Reset
REQ-030 Reset forces IDLE, idx=0, count_out=0, req_out=0, addr_out=0, busy_out=0, done_out=0 and all buffer entries to 0, asynchronously, including mid-scan.
REQ-031 Release is synchronised to clk_in; the first scan requires a start_in after release.

Configuration
REQ-032 Macro OAM_SCAN_EARLY_EXIT_EN defined: when count_out reaches BUFFER_MAX after a store, go to DONE on the next cycle without fetching remaining sprites.
REQ-033 OAM_SCAN_EARLY_EXIT_EN undefined: all NUM_SPRITES entries are always fetched (fixed 2*NUM_SPRITES requests per line) and further hits are discarded.

Verification
REQ-034 ly=0, short mode, sprite 3 Y=16 X=8 and all other Y=0 -> count_out=1, entry {3, 8, 0}, done_out once after 80 requests.
REQ-035 ly=5, tall mode, sprite 7 Y=12 -> hit, row=9; same stimulus in short mode -> no hit.
REQ-036 12 sprites all Y=16, ly=0 -> count_out=10, entries idx 0..9; with EARLY_EXIT_EN the last request is the X byte of idx 9, without it 80 requests are issued.
REQ-037 rvalid_in delayed 0 to 5 cycles at random -> req_out and addr_out stay stable until acceptance; results match the zero-delay run.
REQ-038 Reset asserted mid-scan at idx 20 -> all outputs 0 immediately; a new start_in then produces a full correct scan.
REQ-039 start_in reissued at idx 15 -> count_out cleared, scan restarts at addr OAM_BASE.

Source files
------------

// File: rtl/oam_line_scanner.sv
// oam_line_scanner: fetches Y/X of every OAM sprite and buffers those that cover the current line.
// Define OAM_SCAN_EARLY_EXIT_EN to stop fetching as soon as the buffer fills.
module oam_line_scanner #(
    parameter int          NUM_SPRITES = 40,
    parameter int          BUFFER_MAX  = 10,
    parameter logic [15:0] OAM_BASE    = 16'hFE00,
    localparam int         IDX_W       = $clog2(NUM_SPRITES),
    localparam int         CNT_W       = $clog2(BUFFER_MAX + 1),
    localparam int         ENTRY_W     = IDX_W + 12
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic [7:0]         ly_in,
    input  logic               tall_mode_in,
    output logic               req_out,
    output logic [15:0]        addr_out,
    input  logic [7:0]         rdata_in,
    input  logic               rvalid_in,
    input  logic [CNT_W-1:0]   rd_idx_in,
    output logic [ENTRY_W-1:0] rd_entry_out,
    output logic [CNT_W-1:0]   count_out,
    output logic               busy_out,
    output logic               done_out
);
    typedef enum logic [1:0] {IDLE, REQ_Y, REQ_X, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(BUFFER_MAX);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         ly_q, ly_d, y_q, y_d;
    logic               tall_q, tall_d;
    logic [ENTRY_W-1:0] buf_q [BUFFER_MAX];
    logic [ENTRY_W-1:0] buf_d [BUFFER_MAX];
    logic [1:0]         rst_sync_q, rst_sync_d;
    logic               rst_n;
    logic [8:0]         line9, top9, bot9;
    logic [3:0]         row;
    logic               hit, store;

    // Assertion is immediate through the async clear; release waits two clock edges.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) rst_sync_q <= '0;
        else         rst_sync_q <= rst_sync_d;
    end

    // Sprite Y is stored offset by 16, so compare against ly+16 in 9 bits.
    assign line9 = {1'b0, ly_q} + 9'd16;
    assign top9  = {1'b0, y_q};
    assign bot9  = top9 + (tall_q ? 9'd16 : 9'd8);
    assign row   = ly_q[3:0] - y_q[3:0];
    assign hit   = (top9 <= line9) && (line9 < bot9);
    assign store = hit && (cnt_q < FULL);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ly_d    = ly_q;
        tall_d  = tall_q;
        y_d     = y_q;
        buf_d   = buf_q;
        if (start_in) begin
            state_d = REQ_Y;
            idx_d   = '0;
            cnt_d   = '0;
            ly_d    = ly_in;
            tall_d  = tall_mode_in;
        end else begin
            case (state_q)
                REQ_Y: if (rvalid_in) begin
                    y_d     = rdata_in;
                    state_d = REQ_X;
                end
                REQ_X: if (rvalid_in) begin
                    if (store) begin
                        buf_d[cnt_q] = {idx_q, rdata_in, row};
                        cnt_d        = cnt_q + 1'b1;
                    end
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == LAST_IDX) ? DONE : REQ_Y;
`ifdef OAM_SCAN_EARLY_EXIT_EN
                    if (store && cnt_q == FULL - 1'b1) state_d = DONE;
`endif
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ly_q    <= '0;
            tall_q  <= 1'b0;
            y_q     <= '0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ly_q    <= ly_d;
            tall_q  <= tall_d;
            y_q     <= y_d;
            buf_q   <= buf_d;
        end
    end

    assign busy_out     = (state_q == REQ_Y) || (state_q == REQ_X);
    assign req_out      = busy_out;
    assign done_out     = state_q == DONE;
    assign count_out    = cnt_q;
    assign addr_out     = busy_out ? OAM_BASE + 16'({idx_q, 2'b00}) + {15'd0, state_q == REQ_X} : '0;
    assign rd_entry_out = (rd_idx_in < cnt_q) ? buf_q[rd_idx_in] : '0;
endmodule
